// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for register_file_n
// Purpose: default geometry, address-width helper and zero-register index.
// Optional feature macro used by the top: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned ZERO_REG_IDX  = 0;

  // Address width needed to index 'depth' registers.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/register_n.sv
// rtl/register_n.sv - single WIDTH-bit storage register with load enable
// Ports:
//   Clock  - rising-edge clock
//   Clear  - asynchronous active-high clear
//   Write  - load enable
//   D      - load data
//   Q      - stored value
module register_n #(
  parameter int unsigned WIDTH = regfile_pkg::DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Write,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (Write) q_d = D;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/register_file_n.sv
// rtl/register_file_n.sv - DEPTH x WIDTH register bank with busy scoreboard
// Purpose: one write port, two combinational read ports, per-register busy
//   bits set by Reserve and cleared by Write.
// Ports:
//   Clock, Clear       - clock and asynchronous active-high clear
//   Write, WAddr, D    - write port
//   Reserve, RsvAddr   - marks a register busy
//   RAddrA/B, QA/QB    - combinational read ports
//   BusyA/B, AnyBusy   - busy bit of each read address, OR of all busy bits
// Optional feature: define REGFILE_BYPASS_EN to forward the write port onto
//   matching read ports in the same cycle.
module register_file_n
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AW       = calc_aw(DEPTH),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Write,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] D,
  input  logic             Reserve,
  input  logic [AW-1:0]    RsvAddr,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             BusyA,
  output logic             BusyB,
  output logic             AnyBusy
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG_IDX);

  logic [WIDTH-1:0] reg_data [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Register array; register 0 is hardwired to zero when ZERO_REG is set.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == ZERO_REG_IDX)) begin : g_zero
      assign reg_data[i] = '0;
    end else begin : g_store
      register_n #(.WIDTH(WIDTH)) u_reg (
        .Clock (Clock),
        .Clear (Clear),
        .Write (Write && (WAddr == AW'(i))),
        .D     (D),
        .Q     (reg_data[i])
      );
    end
  end

  // Reserve is applied after Write so a same-address reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (Write)   busy_d[WAddr]   = 1'b0;
    if (Reserve) busy_d[RsvAddr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_REG_IDX] = 1'b0;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  logic [WIDTH-1:0] qa_rd;
  logic [WIDTH-1:0] qb_rd;
  logic             busy_a_rd;
  logic             busy_b_rd;

  always_comb begin
    qa_rd     = reg_data[RAddrA];
    qb_rd     = reg_data[RAddrB];
    busy_a_rd = busy_q[RAddrA];
    busy_b_rd = busy_q[RAddrB];
`ifdef REGFILE_BYPASS_EN
    // Forward the write port; the zero register is never forwarded.
    if (Write && (WAddr == RAddrA) && !((ZERO_REG != 0) && (WAddr == ZERO_ADDR))) begin
      qa_rd     = D;
      busy_a_rd = Reserve && (RsvAddr == RAddrA);
    end
    if (Write && (WAddr == RAddrB) && !((ZERO_REG != 0) && (WAddr == ZERO_ADDR))) begin
      qb_rd     = D;
      busy_b_rd = Reserve && (RsvAddr == RAddrB);
    end
`endif
  end

  // Gate with Clear so forwarded values cannot leak out while cleared.
  assign QA      = Clear ? '0 : qa_rd;
  assign QB      = Clear ? '0 : qb_rd;
  assign BusyA   = !Clear && busy_a_rd;
  assign BusyB   = !Clear && busy_b_rd;
  assign AnyBusy = !Clear && (|busy_q);

  // ZERO_ADDR is only referenced by the bypass path.
  logic unused_ok;
  assign unused_ok = ^ZERO_ADDR;

endmodule

// File: doc/register_file_n.md
# register_file_n

Parametrised multi-register storage block, the successor to the single 64-bit register: DEPTH registers of WIDTH bits, one write port, two combinational read ports, and a per-register busy scoreboard. The datapath uses it as the CPU general-purpose register bank. The control unit reserves a destination register at issue and releases it on write-back, so it can stall on operands that are not yet produced.

## Interface
- WIDTH, 64, bits per register.
- DEPTH, 16, number of registers; power of two, minimum 2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.
- Clock  input  1  single clock; all state updates on the rising edge.
- Clear  input  1  reset, asynchronous and active-high.
- Write  input  1  write enable for the write port.
- WAddr  input  AW  write address.
- D  input  WIDTH  write data.
- Reserve  input  1  marks RsvAddr busy.
- RsvAddr  input  AW  register to reserve.
- RAddrA, RAddrB  input  AW  read addresses.
- QA, QB  output  WIDTH  read data.
- BusyA, BusyB  output  1  busy bit of the addressed register.
- AnyBusy  output  1  OR of all busy bits.

## Operation
- Storage: the register array holds the data; a DEPTH-bit busy vector tracks pending writes.
- Clear asserted: every register and every busy bit is 0 immediately, with no Clock edge needed. QA, QB, BusyA, BusyB and AnyBusy read 0 while Clear is high. Clear overrides Write and Reserve.
- Write: on a rising edge with Write=1, register[WAddr] takes D and busy[WAddr] clears.
- Reserve: on a rising edge with Reserve=1, busy[RsvAddr] is set.
- Same edge, Write and Reserve, same address: data is written and busy ends 1. The new reservation belongs to a younger producer and wins.
- Same edge, different addresses: both actions take effect independently.
- Reads: QA and QB are combinational from the array; BusyA and BusyB are combinational from the busy vector.
- Identical read addresses: RAddrA=RAddrB returns identical data on both ports.
- ZERO_REG=1, address 0: QA/QB read 0, BusyA/BusyB read 0, and Write or Reserve to address 0 is ignored.
- No error state: re-reserving a busy register keeps it busy, and writing a non-busy register is legal.

## Timing
- Write latency is 1 cycle. Data written at edge N is visible on QA/QB after edge N, with no same-cycle forwarding unless REGFILE_BYPASS_EN is defined.
- Busy updates are visible after the edge that causes them.
- Clear takes effect asynchronously. On Clear deassertion, the first edge with Write or Reserve acts normally.
- Clear asserted in the middle of a reservation discards the reservation; the later write still succeeds.

## Configuration
- REGFILE_BYPASS_EN defined: when Write=1 and WAddr equals a read address (excluding address 0 when ZERO_REG=1), that read port returns D and its Busy reads 0 in the same cycle. A simultaneous Reserve to the same address still forces Busy to 1.
- REGFILE_BYPASS_EN undefined: read ports always reflect stored state only, as described above.

## Structure
- Package regfile_pkg holds:
  - the default WIDTH and DEPTH constants;
  - a localparam function for AW;
  - the ZERO_REG index constant.
- Sub-module register_n: a parametrised WIDTH register with D, Clear, Clock, Write and Q ports, instantiated DEPTH times (DEPTH-1 when ZERO_REG=1) in a generate loop.
- Busy vector, read muxes and bypass logic live in the top module.

## Test plan
- Reset: assert Clear mid-cycle with prior contents present -> all Q and Busy outputs are 0 immediately; AnyBusy=0.
- Write/read: write 64'h0006_0000_0003 to r5 and 64'h0000_0006 to r9, read A=r5 and B=r9 -> QA=64'h0006_0000_0003, QB=64'h6.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to r0 and reserve r0 -> QA=0, BusyA=0 when reading r0.
- Scoreboard: reserve r3 -> BusyA=1 and AnyBusy=1. Then write r3=64'h42 -> BusyA=0, QA=64'h42, AnyBusy=0.
- Simultaneous events: reserve and write r7 on the same edge with D=64'h11 -> QA=64'h11, BusyA=1.
- Bypass (REGFILE_BYPASS_EN defined): Write r4=64'hAB while reading r4 -> QA=64'hAB in the same cycle. Without the macro, QA keeps the old value until the edge.
